// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the byte-addressable data memory.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Lanes touched by an access; a misaligned half still yields a mask, the caller gates it by the error flag.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = 4'b0011 << lane;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] r;
    r = wdata;
    case (size)
      SZ_BYTE: r = {4{wdata[7:0]}};
      SZ_HALF: r = {2{wdata[15:0]}};
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Operand is already shifted so the accessed lane sits at bit 0.
  function automatic logic [31:0] extend(input logic [1:0] size, input logic uns,
                                         input logic [31:0] val);
    logic [31:0] r;
    r = '0;
    case (size)
      SZ_BYTE: r = {{24{~uns & val[7]}}, val[7:0]};
      SZ_HALF: r = {{16{~uns & val[15]}}, val[15:0]};
      SZ_WORD: r = val;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Store lane replication / byte enables and load lane extraction / extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  assign be_o    = byte_en(size_i, lane_i);
  assign wdata_o = replicate(size_i, wdata_i);
  assign shifted = rword_i >> {lane_i, 3'b000};
  assign rdata_o = extend(size_i, unsigned_i, shifted);

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressable data memory with post-reset clearing and registered response.
// Optional per-byte parity: define DATA_MEMORY_SIZED_PARITY_EN to add storage and rsp_perr.
module data_memory_sized
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
`ifdef DATA_MEMORY_SIZED_PARITY_EN
  ,
  output logic              rsp_perr
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int AW_LO = IDX_W + 2;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             clr_we;

  logic [31:0]      mem_q [DEPTH];

  logic             accept;
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       lane;
  logic             oor;
  logic             misalign;
  logic             err;
  logic             wr_en;
  logic [31:0]      rword;
  logic [3:0]       be;
  logic [31:0]      wdata_rep;
  logic [31:0]      rdata_ext;

  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q,   rsp_err_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  assign req_ready = (state_q == RUN);
  assign init_done = (state_q == RUN);
  assign accept    = req_valid && req_ready;

  assign word_idx = req_addr[AW_LO-1:2];
  assign lane     = req_addr[1:0];

  // With no address bits above the array, nothing can be out of range.
  generate
    if (ADDR_W > AW_LO) begin : g_range_chk
      assign oor = |req_addr[ADDR_W-1:AW_LO];
    end else begin : g_range_none
      assign oor = 1'b0;
    end
  endgenerate

  always_comb begin
    misalign = 1'b0;
    case (req_size)
      SZ_BYTE: misalign = 1'b0;
      SZ_HALF: misalign = lane[0];
      SZ_WORD: misalign = |lane;
      default: misalign = 1'b1;
    endcase
  end

  assign err   = misalign | oor;
  assign wr_en = accept && req_we && !err;
  assign rword = mem_q[word_idx];

  dmem_lane_align u_lane_align (
    .size_i     (req_size),
    .unsigned_i (req_unsigned),
    .lane_i     (lane),
    .wdata_i    (req_wdata),
    .rword_i    (rword),
    .be_o       (be),
    .wdata_o    (wdata_rep),
    .rdata_o    (rdata_ext)
  );

  // Array has no reset of its own; the CLEAR sweep zeroes it.
  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  always_comb begin
    rsp_valid_d = accept;
    rsp_err_d   = accept && err;
    rsp_rdata_d = (accept && !req_we && !err) ? rdata_ext : 32'h0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

`ifdef DATA_MEMORY_SIZED_PARITY_EN
  logic [3:0] par_q [DEPTH];
  logic [3:0] par_wr;
  logic [3:0] par_rd_calc;
  logic       rsp_perr_q, rsp_perr_d;

  // Even parity: stored bit equals XOR of the byte, so a zeroed byte carries parity 0.
  always_comb begin
    par_wr      = '0;
    par_rd_calc = '0;
    for (int b = 0; b < 4; b++) begin
      par_wr[b]      = ^wdata_rep[8*b +: 8];
      par_rd_calc[b] = ^rword[8*b +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (clr_we) begin
      par_q[clr_cnt_q] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) par_q[word_idx][b] <= par_wr[b];
      end
    end
  end

  assign rsp_perr_d = accept && !req_we && !err &&
                      |((par_q[word_idx] ^ par_rd_calc) & be);

  always_ff @(posedge clock) begin
    if (reset) rsp_perr_q <= 1'b0;
    else       rsp_perr_q <= rsp_perr_d;
  end

  assign rsp_perr = rsp_perr_q;
`endif

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed self-checking bench for data_memory_sized (parity option off).
`timescale 1ns/1ps
module tb_data_memory_sized;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;

  logic              clock;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              init_done;

  int n_cmp = 0;
  int n_err = 0;

  data_memory_sized #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .init_done    (init_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Counts edges until req_ready rises; also notes any response during clearing.
  task automatic wait_ready(output int n, output logic saw_rsp);
    n = 0;
    saw_rsp = 1'b0;
    while (!req_ready && n < 4*DEPTH) begin
      @(posedge clock); #1;
      n++;
      if (rsp_valid) saw_rsp = 1'b1;
    end
  endtask

  task automatic access(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input logic exp_err);
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    check_val({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    check_val({tag, ".rdata"}, rsp_rdata, exp_data);
    check_val({tag, ".err"},   32'(rsp_err),   32'(exp_err));
  endtask

  int   n;
  logic saw;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    check_val("rst.ready", 32'(req_ready), 32'd0);
    check_val("rst.valid", 32'(rsp_valid), 32'd0);
    check_val("rst.rdata", rsp_rdata, 32'd0);
    check_val("rst.err",   32'(rsp_err),   32'd0);
    check_val("rst.init",  32'(init_done), 32'd0);

    // A store offered during clearing must be ignored.
    req_we = 1'b1; req_size = 2'b10; req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
    req_valid = 1'b1;
    reset = 1'b0;
    wait_ready(n, saw);
    req_valid = 1'b0;
    check_val("clear.len", 32'(n), 32'(DEPTH));
    check_val("clear.norsp", 32'(saw), 32'd0);
    check_val("clear.init", 32'(init_done), 32'd1);

    access("ld0",    1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0000_0000, 1'b0);
    access("st8",    1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0);
    access("lbB",    1'b0, 2'b00, 1'b0, 32'hB, 32'h0, 32'hFFFF_FFDE, 1'b0);
    access("lbuB",   1'b0, 2'b00, 1'b1, 32'hB, 32'h0, 32'h0000_00DE, 1'b0);
    access("lh8",    1'b0, 2'b01, 1'b0, 32'h8, 32'h0, 32'hFFFF_BEEF, 1'b0);
    access("lb8",    1'b0, 2'b00, 1'b0, 32'h8, 32'h0, 32'hFFFF_FFEF, 1'b0);
    access("lhuA",   1'b0, 2'b01, 1'b1, 32'hA, 32'h0, 32'h0000_DEAD, 1'b0);
    access("sb9",    1'b1, 2'b00, 1'b0, 32'h9, 32'h0000_0012, 32'h0, 1'b0);
    access("lw8",    1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEAD_12EF, 1'b0);

    access("e.lh3",  1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 32'h0, 1'b1);
    access("e.lw6",  1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1);
    access("e.rsvd", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    access("e.oor",  1'b0, 2'b10, 1'b0, 32'(4*DEPTH), 32'h0, 32'h0, 1'b1);
    access("e.sw6",  1'b1, 2'b10, 1'b0, 32'h6, 32'h5555_5555, 32'h0, 1'b1);
    access("lw4",    1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h0, 1'b0);
    access("lw8b",   1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEAD_12EF, 1'b0);

    access("sh2",    1'b1, 2'b01, 1'b0, 32'h2, 32'h1234_8001, 32'h0, 1'b0);
    access("lb3",    1'b0, 2'b00, 1'b0, 32'h3, 32'h0, 32'hFFFF_FF80, 1'b0);
    access("lbu2",   1'b0, 2'b00, 1'b1, 32'h2, 32'h0, 32'h0000_0001, 1'b0);
    access("lw0",    1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h8001_0000, 1'b0);

    // Back-to-back store then load of the same word.
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'hA5A5_A5A5; req_valid = 1'b1;
    @(posedge clock); #1;
    check_val("b2b.st.valid", 32'(rsp_valid), 32'd1);
    check_val("b2b.st.err",   32'(rsp_err),   32'd0);
    req_we = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    check_val("b2b.ld.valid", 32'(rsp_valid), 32'd1);
    check_val("b2b.ld.rdata", rsp_rdata, 32'hA5A5_A5A5);
    @(posedge clock); #1;
    check_val("b2b.idle.valid", 32'(rsp_valid), 32'd0);

    // Reset in RUN coincident with a load: no response.
    req_we = 1'b0; req_size = 2'b10; req_addr = 32'h8; req_valid = 1'b1;
    reset = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    check_val("rrun.valid", 32'(rsp_valid), 32'd0);
    check_val("rrun.ready", 32'(req_ready), 32'd0);
    reset = 1'b0;

    // Reset again at clear cycle 5; clearing must restart from zero.
    repeat (5) begin @(posedge clock); #1; end
    check_val("mid.ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    wait_ready(n, saw);
    check_val("mid.len", 32'(n), 32'(DEPTH));
    check_val("mid.norsp", 32'(saw), 32'd0);

    access("recl8",  1'b0, 2'b10, 1'b0, 32'h8,  32'h0, 32'h0, 1'b0);
    access("recl10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
